// File: rtl/snn_pkg.sv
// Shared types and constants for the LIF neuron slice.
// Optional feature macro used by this slice: LIF_SPIKE_CNT_EN.
package snn_pkg;

    localparam int V_WIDTH = 16;
    localparam int W_WIDTH = 8;

    localparam logic signed [V_WIDTH-1:0] V_MAX = 16'sh7FFF;
    localparam logic signed [V_WIDTH-1:0] V_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        INTEG  = 2'd0,
        FIRE   = 2'd1,
        REFRAC = 2'd2
    } lif_state_t;

    // Sign-extend a synaptic weight to the saturating-adder delta width.
    function automatic logic signed [V_WIDTH:0] sext_w(input logic signed [W_WIDTH-1:0] w);
        return {{(V_WIDTH + 1 - W_WIDTH){w[W_WIDTH-1]}}, w};
    endfunction

endpackage

// File: rtl/lif_neuron_if.sv
// Synapse-to-neuron weight handshake (valid/ready with signed weight).
interface lif_neuron_if;
    import snn_pkg::*;

    logic                      w_valid;
    logic signed [W_WIDTH-1:0] w_data;
    logic                      w_ready;

    modport master (output w_valid, output w_data, input  w_ready);
    modport slave  (input  w_valid, input  w_data, output w_ready);

endinterface

// File: rtl/lif_sat_add.sv
// Combinational 16-bit signed plus 17-bit signed delta, saturated to 16 bits.
module lif_sat_add
    import snn_pkg::*;
(
    input  logic signed [V_WIDTH-1:0] a,
    input  logic signed [V_WIDTH:0]   delta,
    output logic signed [V_WIDTH-1:0] sum
);

    logic signed [V_WIDTH+1:0] wide;

    // Add at full precision, then clamp once to the 16-bit signed range.
    always_comb begin
        wide = (V_WIDTH + 2)'(a) + (V_WIDTH + 2)'(delta);
        if (wide > (V_WIDTH + 2)'(V_MAX)) begin
            sum = V_MAX;
        end else if (wide < (V_WIDTH + 2)'(V_MIN)) begin
            sum = V_MIN;
        end else begin
            sum = wide[V_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: INTEG -> FIRE -> REFRAC -> INTEG.
// Optional spike counter enabled by defining LIF_SPIKE_CNT_EN.
module lif_neuron
    import snn_pkg::*;
#(
    parameter logic signed [V_WIDTH-1:0] THRESH        = 16'sd1000,
    parameter int                        LEAK_SHIFT    = 4,
    parameter int                        REFRAC_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      kill,
    lif_neuron_if.slave               syn,
    input  logic                      leak_tick,
    output logic                      spike_out,
    output logic signed [V_WIDTH-1:0] v_mem,
    output logic                      refrac,
    output logic [15:0]               spike_cnt
);

    localparam logic [15:0] REFRAC_LOAD = (REFRAC_CYCLES > 0) ? 16'(REFRAC_CYCLES - 1) : 16'd0;

    lif_state_t                state;
    lif_state_t                state_next;
    logic [15:0]               cnt;
    logic                      accept;
    logic signed [V_WIDTH-1:0] leak;
    logic signed [V_WIDTH:0]   wadd;
    logic signed [V_WIDTH:0]   delta;
    logic signed [V_WIDTH-1:0] v_next;

    // Integration delta: leak first, then the accepted weight, as one signed delta.
    always_comb begin
        accept = syn.w_valid && (state == INTEG);
        leak   = '0;
        if (leak_tick) begin
            leak = v_mem >>> LEAK_SHIFT;
        end
        wadd = '0;
        if (accept) begin
            wadd = sext_w(syn.w_data);
        end
        delta = wadd - (V_WIDTH + 1)'(leak);
    end

    lif_sat_add u_sat_add (
        .a     (v_mem),
        .delta (delta),
        .sum   (v_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INTEG;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; kill forces INTEG from any state.
    always_comb begin
        state_next = state;
        case (state)
            INTEG: begin
                if (v_next >= THRESH) begin
                    state_next = FIRE;
                end
            end
            FIRE: begin
                state_next = (REFRAC_CYCLES == 0) ? INTEG : REFRAC;
            end
            REFRAC: begin
                if (cnt == '0) begin
                    state_next = INTEG;
                end
            end
            default: state_next = INTEG;
        endcase
        if (kill) begin
            state_next = INTEG;
        end
    end

    // State-decoded outputs.
    always_comb begin
        syn.w_ready = (state == INTEG);
        spike_out   = (state == FIRE);
        refrac      = (state == REFRAC);
    end

    // Membrane potential and refractory counter.
    always_ff @(posedge clk) begin
        if (rst || kill) begin
            v_mem <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                INTEG: begin
                    v_mem <= v_next;
                end
                FIRE: begin
                    v_mem <= '0;
                    cnt   <= REFRAC_LOAD;
                end
                REFRAC: begin
                    v_mem <= '0;
                    if (cnt != '0) begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    v_mem <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef LIF_SPIKE_CNT_EN
    logic [15:0] spike_cnt_q;

    // Saturating count of FIRE cycles.
    always_ff @(posedge clk) begin
        if (rst || kill) begin
            spike_cnt_q <= '0;
        end else if ((state == FIRE) && (spike_cnt_q != '1)) begin
            spike_cnt_q <= spike_cnt_q + 16'd1;
        end
    end

    // Expose the counter.
    always_comb begin
        spike_cnt = spike_cnt_q;
    end
`else
    // Counter absent: port tied low.
    always_comb begin
        spike_cnt = '0;
    end
`endif

endmodule

// File: tb/tb_lif_neuron.sv
// Scoreboard bench for lif_neuron (THRESH=100, LEAK_SHIFT=2, REFRAC_CYCLES=3).
module tb_lif_neuron;

    logic               clk = 1'b0;
    logic               rst;
    logic               kill;
    logic               leak_tick;
    logic               spike_out;
    logic               refrac;
    logic signed [15:0] v_mem;
    logic [15:0]        spike_cnt;

`ifdef LIF_SPIKE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    lif_neuron_if syn ();

    lif_neuron #(
        .THRESH        (16'sd100),
        .LEAK_SHIFT    (2),
        .REFRAC_CYCLES (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .kill      (kill),
        .syn       (syn),
        .leak_tick (leak_tick),
        .spike_out (spike_out),
        .v_mem     (v_mem),
        .refrac    (refrac),
        .spike_cnt (spike_cnt)
    );

    typedef struct {
        int                 id;
        logic signed [15:0] v;
        logic               sp;
        logic               rdy;
        logic               rf;
        logic [15:0]        cnt;
    } exp_t;

    exp_t sbq[$];
    int   errors  = 0;
    int   checks  = 0;
    int   step_id = 0;
    logic prev_spike = 1'b0;

    // Drive one cycle of inputs and queue the state expected after the next edge.
    task automatic step(input logic r, input logic k, input logic wv,
                        input logic signed [7:0] wd, input logic lt,
                        input logic signed [15:0] ev, input logic esp,
                        input logic erdy, input logic erf, input logic [15:0] ecnt);
        exp_t e;
        @(negedge clk);
        rst           = r;
        kill          = k;
        syn.w_valid   = wv;
        syn.w_data    = wd;
        leak_tick     = lt;
        e.id  = step_id;
        e.v   = ev;
        e.sp  = esp;
        e.rdy = erdy;
        e.rf  = erf;
        e.cnt = CNT_EN ? ecnt : 16'd0;
        sbq.push_back(e);
        step_id++;
    endtask

    // Monitor: after each edge, pop the pending expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if (v_mem !== e.v || spike_out !== e.sp || syn.w_ready !== e.rdy ||
                    refrac !== e.rf || spike_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL step%0d: got v=%0d sp=%b rdy=%b ref=%b cnt=%0d, want v=%0d sp=%b rdy=%b ref=%b cnt=%0d",
                             e.id, v_mem, spike_out, syn.w_ready, refrac, spike_cnt,
                             e.v, e.sp, e.rdy, e.rf, e.cnt);
                end
                if (spike_out === 1'b1) begin
                    checks++;
                    if (prev_spike === 1'b1) begin
                        errors++;
                        $display("FAIL spike_back_to_back step%0d: got two consecutive spikes, want isolated pulse", e.id);
                    end
                end
                prev_spike = spike_out;
            end
        end
    end

    initial begin
        rst         = 1'b1;
        kill        = 1'b0;
        leak_tick   = 1'b0;
        syn.w_valid = 1'b0;
        syn.w_data  = '0;

        // reset for two cycles
        step(1, 0, 0, 0, 0,      0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0,      0, 0, 1, 0, 0);

        // 40, 40, 30 -> fire, then 3 refractory cycles
        step(0, 0, 1, 40, 0,     40, 0, 1, 0, 0);
        step(0, 0, 1, 40, 0,     80, 0, 1, 0, 0);
        step(0, 0, 1, 30, 0,    110, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0,       0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0,       0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0,       0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0,       0, 0, 1, 0, 1);

        // leak: 80 -> 60 -> 45, hold, -7 -> -5
        step(0, 0, 1, 80, 0,     80, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1,      60, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1,      45, 0, 1, 0, 1);
        step(0, 0, 0, 99, 0,     45, 0, 1, 0, 1);
        step(0, 0, 1, -52, 0,    -7, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1,      -5, 0, 1, 0, 1);

        // leak and weight together: 80 - 20 + 50 = 110 -> fire
        step(0, 0, 1, 85, 0,     80, 0, 1, 0, 1);
        step(0, 0, 1, 50, 1,    110, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0,       0, 0, 0, 1, 2);
        step(0, 0, 0, 0, 0,       0, 0, 0, 1, 2);
        step(0, 0, 0, 0, 0,       0, 0, 0, 1, 2);
        step(0, 0, 0, 0, 0,       0, 0, 1, 0, 2);

        // drive toward negative saturation
        for (int i = 1; i <= 255; i++) begin
            step(0, 0, 1, -128, 0, 16'(-128 * i), 0, 1, 0, 2);
        end
        step(0, 0, 1, -60, 0,  -32700, 0, 1, 0, 2);
        step(0, 0, 1, -128, 0, -32768, 0, 1, 0, 2);
        step(0, 0, 1, -128, 0, -32768, 0, 1, 0, 2);
        step(0, 0, 0, 0, 1,    -24576, 0, 1, 0, 2);

        // kill in INTEG discards the weight and clears the count
        step(0, 1, 1, 50, 0,      0, 0, 1, 0, 0);

        // kill during the second refractory cycle
        step(0, 0, 1, 100, 0,   100, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0,       0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0,       0, 0, 0, 1, 1);
        step(0, 1, 0, 0, 0,       0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0,       0, 0, 1, 0, 0);

        // w_valid held with 127 through FIRE/REFRAC
        step(0, 0, 1, 127, 0,   127, 1, 0, 0, 0);
        step(0, 0, 1, 127, 0,     0, 0, 0, 1, 1);
        step(0, 0, 1, 127, 0,     0, 0, 0, 1, 1);
        step(0, 0, 1, 127, 0,     0, 0, 0, 1, 1);
        step(0, 0, 1, 127, 0,     0, 0, 1, 0, 1);
        step(0, 0, 1, 127, 0,   127, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0,       0, 0, 0, 1, 2);

        // reset aborts REFRAC and FIRE, and wins over kill
        step(1, 0, 0, 0, 0,       0, 0, 1, 0, 0);
        step(0, 0, 1, 120, 0,   120, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0,       0, 0, 1, 0, 0);
        step(1, 1, 1, 120, 1,     0, 0, 1, 0, 0);
        step(0, 0, 1, -1, 1,     -1, 0, 1, 0, 0);

        @(negedge clk);
        rst         = 1'b0;
        kill        = 1'b0;
        syn.w_valid = 1'b0;
        leak_tick   = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
